// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_pkg
//  Purpose  : Shared types and constants for the PCS link controller slice.
//             Holds the link state encoding, the valid sync header codes,
//             a header classifier and a counter width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package pcs_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESET     = 2'd1,
    WAIT_LOCK = 2'd2,
    LINK_UP   = 2'd3
  } link_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // 2'b00 and 2'b11 can never be produced by a healthy 64b/66b link.
  function automatic logic is_bad_header(input logic [1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

  // Width of a counter holding 0..n-1; kept at least 1 bit wide so a
  // parameter of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ber_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : ber_monitor
//  Purpose  : Counts qualified sync headers in fixed windows of BER_WINDOW
//             headers and raises o_hi_ber once BER_THRESH bad headers have
//             been seen inside one window.
//  Ports    : i_clk      - clock
//             i_reset_n  - asynchronous active-low reset
//             i_clear    - synchronous clear of counters and flag
//             i_header   - received sync header
//             i_valid    - i_header is to be counted this cycle
//             o_hi_ber   - high bit-error-rate flag (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module ber_monitor
  import pcs_pkg::*;
#(
  parameter int BER_WINDOW = 3125,
  parameter int BER_THRESH = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clear,
  input  logic [1:0] i_header,
  input  logic       i_valid,
  output logic       o_hi_ber
);

  localparam int HDR_W = cnt_width(BER_WINDOW);
  localparam int BAD_W = cnt_width(BER_THRESH + 1);

  localparam logic [HDR_W-1:0] c_hdr_last = HDR_W'(BER_WINDOW - 1);
  localparam logic [BAD_W-1:0] c_bad_max  = BAD_W'(BER_THRESH);

  logic [HDR_W-1:0] r_hdr_cnt;
  logic [BAD_W-1:0] r_bad_cnt;
  logic             r_hi_ber;

  logic             w_bad;
  logic [BAD_W-1:0] w_bad_next;
  logic             w_win_end;
  logic             w_thresh_hit;

  // w_bad_next is the bad count including the current header, so the
  // header that closes a window is judged together with that window.
  always_comb begin
    w_bad      = is_bad_header(i_header);
    w_bad_next = r_bad_cnt;
    if (w_bad && (r_bad_cnt != c_bad_max)) begin
      w_bad_next = r_bad_cnt + BAD_W'(1);
    end
    w_win_end    = (r_hdr_cnt == c_hdr_last);
    w_thresh_hit = (w_bad_next == c_bad_max);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hdr_cnt <= '0;
      r_bad_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (i_clear) begin
      r_hdr_cnt <= '0;
      r_bad_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (i_valid) begin
      if (w_win_end) begin
        // Window closes: flag follows this window's verdict, counters restart.
        r_hdr_cnt <= '0;
        r_bad_cnt <= '0;
        r_hi_ber  <= w_thresh_hit;
      end else begin
        r_hdr_cnt <= r_hdr_cnt + HDR_W'(1);
        r_bad_cnt <= w_bad_next;
        if (w_thresh_hit) begin
          r_hi_ber <= 1'b1;
        end
      end
    end
  end

  assign o_hi_ber = r_hi_ber;

endmodule
`default_nettype wire

// File: rtl/pcs_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_link_ctrl
//  Purpose  : PCS link bring-up controller. Holds the PCS in reset until the
//             transceiver is ready, waits for block lock with a timeout,
//             retries on lock loss / high BER / restart requests and counts
//             retries. All outputs are registered.
//  Ports    : i_clk          - PCS rx clock
//             i_reset_n      - asynchronous active-low reset; deassertion is
//                              expected to be synchronous to i_clk
//             i_xver_ready   - transceiver reset done / CDR locked
//             i_restart      - single-cycle request for a new reset attempt
//             i_block_lock   - block lock from the lock state machine
//             i_rx_header    - received sync header
//             i_rx_valid     - i_rx_header qualifier
//             o_pcs_reset    - active-high reset to PCS tx/rx
//             o_link_up      - link operational
//             o_hi_ber       - high bit-error-rate flag
//             o_retry_count  - reset attempts after the first, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module pcs_link_ctrl
  import pcs_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int BER_WINDOW   = 3125,
  parameter int BER_THRESH   = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_xver_ready,
  input  logic       i_restart,
  input  logic       i_block_lock,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_valid,
  output logic       o_pcs_reset,
  output logic       o_link_up,
  output logic       o_hi_ber,
  output logic [7:0] o_retry_count
);

  localparam int RST_W  = cnt_width(RESET_CYCLES);
  localparam int LOCK_W = cnt_width(LOCK_TIMEOUT);

  localparam logic [RST_W-1:0]  c_rst_last  = RST_W'(RESET_CYCLES - 1);
  localparam logic [LOCK_W-1:0] c_lock_last = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]        c_retry_max = 8'hFF;

  link_state_t       r_state;
  link_state_t       w_state_next;
  logic              w_retry_inc;

  logic [RST_W-1:0]  r_rst_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_pcs_reset;
  logic              r_link_up;
  logic [7:0]        r_retry_cnt;

  logic              w_ber_clear;
  logic              w_hdr_valid;
  logic              w_hi_ber;

  // --------------------------------------------------------------------------
  // Next-state logic. Loss of transceiver readiness wins over everything and
  // is not a retry; every other entry into RESET from WAIT_LOCK or LINK_UP is.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_retry_inc  = 1'b0;
    if (!i_xver_ready) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = RESET;
        end
        RESET: begin
          // i_restart deliberately ignored: the reset pulse runs to completion.
          if (r_rst_cnt == c_rst_last) begin
            w_state_next = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (i_restart) begin
            w_state_next = RESET;
            w_retry_inc  = 1'b1;
          end else if (i_block_lock) begin
            w_state_next = LINK_UP;
          end else if (r_lock_cnt == c_lock_last) begin
            w_state_next = RESET;
            w_retry_inc  = 1'b1;
          end
        end
        LINK_UP: begin
          if (i_restart || !i_block_lock || w_hi_ber) begin
            w_state_next = RESET;
            w_retry_inc  = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Dwell counters restart on every state entry. Outputs are decoded from the
  // next state so they line up with the state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rst_cnt   <= '0;
      r_lock_cnt  <= '0;
      r_pcs_reset <= 1'b1;
      r_link_up   <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      if ((r_state == RESET) && (w_state_next == RESET)) begin
        r_rst_cnt <= r_rst_cnt + RST_W'(1);
      end else begin
        r_rst_cnt <= '0;
      end

      if ((r_state == WAIT_LOCK) && (w_state_next == WAIT_LOCK)) begin
        r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
      end else begin
        r_lock_cnt <= '0;
      end

      r_pcs_reset <= (w_state_next == IDLE) || (w_state_next == RESET);
      r_link_up   <= (w_state_next == LINK_UP);

      if (w_retry_inc && (r_retry_cnt != c_retry_max)) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // BER monitor: only headers seen while locked and out of reset count; any
  // lock loss or reset phase discards the partial window.
  // --------------------------------------------------------------------------
  assign w_ber_clear = !i_block_lock || (r_state == IDLE) || (r_state == RESET);
  assign w_hdr_valid = i_rx_valid && i_block_lock && !r_pcs_reset;

  ber_monitor #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_monitor (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_ber_clear),
    .i_header  (i_rx_header),
    .i_valid   (w_hdr_valid),
    .o_hi_ber  (w_hi_ber)
  );

  assign o_pcs_reset   = r_pcs_reset;
  assign o_link_up     = r_link_up;
  assign o_hi_ber      = w_hi_ber;
  assign o_retry_count = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcs_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcs_link_ctrl
//  Purpose  : Self-checking bench for pcs_link_ctrl: bring-up and hi-BER
//             vector table, below-threshold windows, lock timeout with retry
//             saturation, priority of transceiver-not-ready, restart during
//             RESET and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_link_ctrl;

  localparam int RESET_CYCLES = 16;
  localparam int LOCK_TIMEOUT = 100;
  localparam int BER_WINDOW   = 64;
  localparam int BER_THRESH   = 16;
  localparam int PERIOD       = RESET_CYCLES + LOCK_TIMEOUT;
  localparam int NVEC         = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       xver_ready;
  logic       restart;
  logic       block_lock;
  logic [1:0] rx_header;
  logic       rx_valid;
  logic       pcs_reset;
  logic       link_up;
  logic       hi_ber;
  logic [7:0] retry_count;

  typedef struct packed {
    logic       pcs_reset;
    logic       link_up;
    logic       hi_ber;
    logic [7:0] retry;
  } out_t;

  typedef struct packed {
    logic       xver;
    logic       restart;
    logic       lock;
    logic [1:0] hdr;
    logic       valid;
    out_t       want;
  } vec_t;

  vec_t vecs [NVEC];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pcs_link_ctrl #(
    .RESET_CYCLES (RESET_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .BER_WINDOW   (BER_WINDOW),
    .BER_THRESH   (BER_THRESH)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_xver_ready  (xver_ready),
    .i_restart     (restart),
    .i_block_lock  (block_lock),
    .i_rx_header   (rx_header),
    .i_rx_valid    (rx_valid),
    .o_pcs_reset   (pcs_reset),
    .o_link_up     (link_up),
    .o_hi_ber      (hi_ber),
    .o_retry_count (retry_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic out_t mk(input logic r, input logic u, input logic b, input int t);
    out_t o;
    o.pcs_reset = r;
    o.link_up   = u;
    o.hi_ber    = b;
    o.retry     = t[7:0];
    return o;
  endfunction

  task automatic check(input string name, input out_t want);
    out_t got;
    got.pcs_reset = pcs_reset;
    got.link_up   = link_up;
    got.hi_ber    = hi_ber;
    got.retry     = retry_count;
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got pcs_reset=%b link_up=%b hi_ber=%b retry=%0d, expected pcs_reset=%b link_up=%b hi_ber=%b retry=%0d",
               name, got.pcs_reset, got.link_up, got.hi_ber, got.retry,
               want.pcs_reset, want.link_up, want.hi_ber, want.retry);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic x, input logic r, input logic l,
                       input logic [1:0] h, input logic v);
    xver_ready = x;
    restart    = r;
    block_lock = l;
    rx_header  = h;
    rx_valid   = v;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic wait_link(input string name);
    int k;
    k = 0;
    while (link_up !== 1'b1 && k < 200) begin
      cyc();
      k++;
    end
    n_vec++;
    if (link_up !== 1'b1) begin
      n_err++;
      $display("FAIL %s: link_up=%b after %0d cycles, expected 1", name, link_up, k);
    end
  endtask

  // xver_ready and block_lock already high: RESET for 16 cycles, one
  // WAIT_LOCK cycle, then LINK_UP. Optional restart pulse at cycle pulse_at.
  task automatic bringup_seq(input string name, input int retry, input int pulse_at);
    for (int c = 0; c < RESET_CYCLES + 2; c++) begin
      restart = (c == pulse_at);
      cyc();
      restart = 1'b0;
      check($sformatf("%s[%0d]", name, c),
            mk(c < RESET_CYCLES, c == RESET_CYCLES + 1, 1'b0, retry));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    // Bring-up with lock at cycle 40, then 16 bad headers inside one window.
    for (int c = 0; c < NVEC; c++) begin
      vecs[c].xver    = 1'b1;
      vecs[c].restart = 1'b0;
      vecs[c].lock    = (c >= 40);
      vecs[c].hdr     = (c >= 46 && c <= 61) ? 2'b11 : 2'b01;
      vecs[c].valid   = (c <= 61);
      if (c < 16)       vecs[c].want = mk(1'b1, 1'b0, 1'b0, 0);
      else if (c < 40)  vecs[c].want = mk(1'b0, 1'b0, 1'b0, 0);
      else if (c < 61)  vecs[c].want = mk(1'b0, 1'b1, 1'b0, 0);
      else if (c == 61) vecs[c].want = mk(1'b0, 1'b1, 1'b1, 0);
      else if (c == 62) vecs[c].want = mk(1'b1, 1'b0, 1'b1, 1);
      else              vecs[c].want = mk(1'b1, 1'b0, 1'b0, 1);
    end

    repeat (3) @(negedge clk);
    check("reset_state", mk(1'b1, 1'b0, 1'b0, 0));
    reset_n = 1'b1;
    cyc();
    check("idle_hold", mk(1'b1, 1'b0, 1'b0, 0));

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].xver, vecs[i].restart, vecs[i].lock, vecs[i].hdr, vecs[i].valid);
      exp_q.push_back(vecs[i].want);
      cyc();
      check($sformatf("bringup_hiber[%0d]", i), exp_q.pop_front());
    end

    // 15 bad headers per window, packed against alternating window edges so a
    // misplaced boundary would gather 16 into one window.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    wait_link("below_thresh_bringup");
    for (int w = 0; w < 4; w++) begin
      for (int p = 0; p < BER_WINDOW; p++) begin
        logic bad;
        bad = (w % 2 == 0) ? (p >= BER_WINDOW - 15) : (p < 15);
        drive(1'b1, 1'b0, 1'b1, bad ? 2'b11 : ((p % 2 == 1) ? 2'b10 : 2'b01), 1'b1);
        cyc();
        check($sformatf("below_thresh[w%0d p%0d]", w, p), mk(1'b0, 1'b1, 1'b0, 0));
      end
    end
    rx_valid = 1'b0;

    // Never lock: RESET re-entered every PERIOD cycles, retry saturating at 255.
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    for (int c = 0; c <= 257 * PERIOD; c++) begin
      int r;
      cyc();
      r = (c / PERIOD > 255) ? 255 : c / PERIOD;
      check($sformatf("timeout[%0d]", c), mk((c % PERIOD) < RESET_CYCLES, 1'b0, 1'b0, r));
    end

    // Restart, lock loss, then xver drop concurrent with restart and lock loss.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    wait_link("prio_bringup1");
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_in_linkup", mk(1'b1, 1'b0, 1'b0, 1));
    wait_link("prio_bringup2");
    block_lock = 1'b0;
    cyc();
    block_lock = 1'b1;
    check("lock_loss", mk(1'b1, 1'b0, 1'b0, 2));
    wait_link("prio_bringup3");
    drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc();
    restart = 1'b0;
    check("prio_xver_low", mk(1'b1, 1'b0, 1'b0, 2));
    cyc();
    check("prio_idle_hold", mk(1'b1, 1'b0, 1'b0, 2));
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    bringup_seq("restart_in_reset", 2, 5);

    // Asynchronous reset in the middle of RESET, between clock edges.
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("enter_reset", mk(1'b1, 1'b0, 1'b0, 3));
    cyc();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", mk(1'b1, 1'b0, 1'b0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    bringup_seq("post_reset_bringup", 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcs_link_ctrl.md
PCS_LINK_CTRL -- requirements
Module: pcs_link_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, cycles o_pcs_reset is held per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, cycles allowed in WAIT_LOCK before retrying.
REQ-003 SHALL have parameter BER_WINDOW, default 3125, number of valid headers per BER window.
REQ-004 SHALL have parameter BER_THRESH, default 16, number of bad headers in one window that sets hi_ber.
REQ-005 SHALL have port i_clk, input, 1, the single clock (PCS rx clock).
REQ-006 SHALL have port i_reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port i_xver_ready, input, 1, transceiver reset done / CDR locked.
REQ-008 SHALL have port i_restart, input, 1, single-cycle request to force a new reset attempt.
REQ-009 SHALL have port i_block_lock, input, 1, block lock from the lock state machine.
REQ-010 SHALL have port i_rx_header, input, 2, received sync header.
REQ-011 SHALL have port i_rx_valid, input, 1, i_rx_header qualifier (gearbox valid).
REQ-012 SHALL have port o_pcs_reset, output, 1, active-high synchronous reset driven to PCS tx_reset/rx_reset.
REQ-013 SHALL have port o_link_up, output, 1, link operational.
REQ-014 SHALL have port o_hi_ber, output, 1, high bit-error-rate flag.
REQ-015 SHALL have port o_retry_count, output, 8, number of reset attempts after the first, saturating.

Function
REQ-016 SHALL implement states IDLE, RESET, WAIT_LOCK, LINK_UP; all outputs registered, changing the cycle after the causing condition is sampled.
REQ-017 IDLE: o_pcs_reset=1, o_link_up=0; go to RESET when i_xver_ready=1.
REQ-018 RESET: o_pcs_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
REQ-019 WAIT_LOCK: o_pcs_reset=0; go to LINK_UP when i_block_lock=1; go to RESET when i_block_lock stays 0 for LOCK_TIMEOUT cycles, and increment o_retry_count.
REQ-020 LINK_UP: o_link_up=1; go to RESET and increment o_retry_count when i_block_lock=0 or o_hi_ber=1.
REQ-021 i_xver_ready=0 in any state SHALL force IDLE next cycle, with priority over all other transitions; o_retry_count is not incremented.
REQ-022 i_restart=1 in WAIT_LOCK or LINK_UP SHALL go to RESET and increment o_retry_count; ignored in IDLE and RESET (RESET counter not restarted).
REQ-023 o_retry_count SHALL saturate at 255, never wrap.
REQ-024 Header classification: 2'b01 and 2'b10 good, 2'b00 and 2'b11 bad; counted only when i_rx_valid=1, i_block_lock=1 and o_pcs_reset=0.
REQ-025 BER monitor SHALL count counted headers to BER_WINDOW and bad headers saturating at BER_THRESH; the header that completes the window belongs to that window.
REQ-026 o_hi_ber SHALL set the cycle after the bad count reaches BER_THRESH, independent of window position.
REQ-027 At window end, if bad count < BER_THRESH, o_hi_ber SHALL clear; both counters restart from 0 in every case.
REQ-028 BER counters and o_hi_ber SHALL clear whenever i_block_lock=0 or state is IDLE or RESET.

Reset
REQ-029 On i_reset_n=0: state IDLE, o_pcs_reset=1, o_link_up=0, o_hi_ber=0, o_retry_count=0, all internal counters 0; asserted asynchronously, released synchronously to i_clk.

Structure
REQ-030 Package pcs_pkg SHALL hold the state enum link_state_t and constants SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
REQ-031 BER logic SHALL be a sub-module ber_monitor (ports i_clk, i_reset_n, i_clear, i_header, i_valid, o_hi_ber), parameterised by BER_WINDOW, BER_THRESH.
REQ-032 Counter widths SHALL be derived with $clog2 from the parameters.

Verification
REQ-033 Bring-up: i_xver_ready=1 at cycle 0, i_block_lock=1 at cycle 40 -> o_pcs_reset=1 for 16 cycles, then 0, o_link_up=1 at cycle 41, o_retry_count=0.
REQ-034 Timeout: LOCK_TIMEOUT=100, never lock -> RESET re-entered every 116 cycles; o_retry_count 1,2,3..., saturating at 255 after 255 retries.
REQ-035 Hi-BER: BER_WINDOW=64, in LINK_UP send 16 headers 2'b11 within one window -> o_hi_ber=1 the cycle after the 16th, then o_link_up=0 and o_pcs_reset=1.
REQ-036 Below threshold: 15 bad headers per 64-header window for 4 windows -> o_hi_ber stays 0, o_link_up stays 1.
REQ-037 Priority: i_xver_ready=0 concurrent with i_restart=1 and lock loss in LINK_UP -> IDLE next cycle, o_retry_count unchanged.
REQ-038 Async reset: i_reset_n=0 mid-RESET between clock edges -> outputs reach reset values before next edge; retry count 0.
